// File: rtl/loading_bar_axil_slave_if.sv
// AXI4-Lite bus bundle for the loading bar peripheral.
// The master modport drives requests; the slave modport answers them.
interface loading_bar_axil_slave_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/loading_bar_axil_slave.sv
// AXI4-Lite register block driving a progress bar: CTRL/TOTAL/PROGRESS/DISP
// registers, tick counter and an iterative level computation feeding led_o.
module loading_bar_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned N_LEDS             = 8
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    loading_bar_axil_slave_if.slave s00_axi,
    input  logic                    tick_i,
    output logic [N_LEDS-1:0]       led_o,
    output logic                    busy_o
);
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned KW = $clog2(N_LEDS + 1);
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_TOTAL    = 2'd1;
    localparam logic [1:0] REG_PROGRESS = 2'd2;
    localparam logic [1:0] REG_DISP     = 2'd3;

    typedef enum logic {IDLE, CALC} state_t;

    logic [DW-1:0] ctrl_q, total_q, progress_q, disp_q;
    logic          wr_ready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q, rd_mux;
    logic          wr_en;
    logic [1:0]    wr_sel;

    state_t        state_q, state_d;
    logic [DW-1:0] prog_snap_q, total_snap_q;
    logic [47:0]   target_q, acc_q;
    logic [KW-1:0] k_q, lvl_acc_q, lvl_next, level_q;
    logic          change, last_k;
    logic [N_LEDS-1:0] therm, led_q;
    logic          unused_bits;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] data,
                                                 input logic [DW/8-1:0] strb);
        logic [DW-1:0] res;
        res = old;
        for (int unsigned b = 0; b < DW/8; b++)
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        return res;
    endfunction

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign wr_en  = wr_ready_q && s00_axi.awvalid && s00_axi.wvalid;
    assign wr_sel = s00_axi.awaddr[3:2];

    assign s00_axi.awready = wr_ready_q;
    assign s00_axi.wready  = wr_ready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;

    always_comb begin
        rd_mux = '0;
        case (s00_axi.araddr[3:2])
            REG_CTRL:     rd_mux = ctrl_q;
            REG_TOTAL:    rd_mux = total_q;
            REG_PROGRESS: rd_mux = progress_q;
            default:      rd_mux = disp_q;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            wr_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wr_ready_q <= !wr_ready_q && s00_axi.awvalid && s00_axi.wvalid && !bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= 2'b00;
            end else if (s00_axi.bready) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= !arready_q && s00_axi.arvalid && !rvalid_q;
            if (arready_q && s00_axi.arvalid) begin
                rvalid_q <= 1'b1;
                rresp_q  <= 2'b00;
                rdata_q  <= rd_mux;
            end else if (s00_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // PROGRESS priority: bus write, then CTRL[1] clear, then tick increment.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            ctrl_q     <= '0;
            total_q    <= '0;
            progress_q <= '0;
            disp_q     <= '0;
        end else begin
            if (wr_en && wr_sel == REG_CTRL)
                ctrl_q <= apply_strb(ctrl_q, s00_axi.wdata, s00_axi.wstrb);
            else if (ctrl_q[1])
                ctrl_q[1] <= 1'b0;

            if (wr_en && wr_sel == REG_TOTAL)
                total_q <= apply_strb(total_q, s00_axi.wdata, s00_axi.wstrb);
            if (wr_en && wr_sel == REG_DISP)
                disp_q <= apply_strb(disp_q, s00_axi.wdata, s00_axi.wstrb);

            if (wr_en && wr_sel == REG_PROGRESS)
                progress_q <= apply_strb(progress_q, s00_axi.wdata, s00_axi.wstrb);
            else if (ctrl_q[1])
                progress_q <= '0;
            else if (ctrl_q[0] && tick_i && progress_q != '1)
                progress_q <= progress_q + DW'(1);
        end
    end

    // Snapshots detect changes; CALC works on the snapshot so a restart is just a reload.
    assign change   = (progress_q != prog_snap_q) || (total_q != total_snap_q);
    assign last_k   = (k_q == KW'(N_LEDS));
    assign lvl_next = (target_q >= acc_q) ? k_q : lvl_acc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (change) state_d = CALC;
            CALC:    if (!change && last_k) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            prog_snap_q  <= '0;
            total_snap_q <= '0;
            target_q     <= '0;
            acc_q        <= '0;
            k_q          <= '0;
            lvl_acc_q    <= '0;
            level_q      <= '0;
        end else if (change) begin
            prog_snap_q  <= progress_q;
            total_snap_q <= total_q;
            target_q     <= 48'(progress_q) * 48'(N_LEDS);
            acc_q        <= 48'(total_q);
            k_q          <= KW'(1);
            lvl_acc_q    <= '0;
        end else if (state_q == CALC) begin
            if (last_k) begin
                level_q <= (total_snap_q == '0) ? '0 : lvl_next;
            end else begin
                lvl_acc_q <= lvl_next;
                acc_q     <= acc_q + 48'(total_snap_q);
                k_q       <= k_q + KW'(1);
            end
        end
    end

    always_comb begin
        therm = '0;
        for (int unsigned i = 0; i < N_LEDS; i++)
            therm[i] = (i < 32'(level_q));
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) led_q <= '0;
        else                  led_q <= disp_q[16] ? disp_q[N_LEDS-1:0] : therm;
    end

    assign led_o  = led_q;
    assign busy_o = (state_q == CALC);
endmodule
